// File: rtl/spi_ram_slave_v2_if.sv
`default_nettype none
// ============================================================================
// spi_ram_slave_v2_if : host-side serial pins and status flags of the SPI RAM
// Revision: 2.0
// ============================================================================
interface spi_ram_slave_v2_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic frame_err;
  logic addr_err;

  modport master (
    output SS_n, MOSI,
    input  MISO, busy, frame_err, addr_err
  );

  modport slave (
    input  SS_n, MOSI,
    output MISO, busy, frame_err, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_ram_slave_v2.sv
`default_nettype none
// ============================================================================
// spi_ram_slave_v2 : clk-sampled SPI slave front end on a single-port RAM
// Revision: 2.0
// ============================================================================
module spi_ram_slave_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  spi_ram_slave_v2_if.slave bus
);

  localparam int                CNT_W       = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  C_CMD_LAST  = CNT_W'(1);
  localparam logic [ADDR_WIDTH:0] C_DEPTH     = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_LAST_ADDR = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
  localparam logic [1:0] C_WR_ADDR = 2'b00;
  localparam logic [1:0] C_WR_DATA = 2'b01;
  localparam logic [1:0] C_RD_ADDR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_EXEC     = 3'd3,
    S_READ_OUT = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic [DATA_WIDTH-1:0]  tx_q, tx_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   addr_err_q, addr_err_d;
  logic                   mem_we;
  logic                   wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  assign wr_in_range = {1'b0, wr_addr_q} < C_DEPTH;
  assign rd_in_range = {1'b0, rd_addr_q} < C_DEPTH;

  // Post-access address step; wraps at the last implemented word, not at 2**ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a);
    if (AUTO_INC == 0)           return a;
    if ({1'b0, a} == C_LAST_ADDR) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.SS_n) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (bus.SS_n) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          cmd_d = {cmd_q[0], bus.MOSI};
          if (cnt_q == C_CMD_LAST) begin
            cnt_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.SS_n) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          rx_d = {rx_q[DATA_WIDTH-2:0], bus.MOSI};
          if (cnt_q == C_LAST_BIT) begin
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_EXEC: begin
        case (cmd_q)
          C_WR_ADDR: wr_addr_d = rx_q[ADDR_WIDTH-1:0];
          C_WR_DATA: begin
            if (wr_in_range) begin
              mem_we    = 1'b1;
              wr_addr_d = step_addr(wr_addr_q);
            end else begin
              addr_err_d = 1'b1;
            end
          end
          C_RD_ADDR: rd_addr_d = rx_q[ADDR_WIDTH-1:0];
          default: begin
            if (rd_in_range) begin
              tx_d      = mem[rd_addr_q];
              rd_addr_d = step_addr(rd_addr_q);
            end else begin
              tx_d       = '0;
              addr_err_d = 1'b1;
            end
          end
        endcase
        // A deselect here lets the command finish but skips any read-out.
        if (bus.SS_n)             state_d = S_IDLE;
        else if (cmd_q == 2'b11)  state_d = S_READ_OUT;
        else                      state_d = S_CMD;
      end
      S_READ_OUT: begin
        if (bus.SS_n && (cnt_q != C_LAST_BIT)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == C_LAST_BIT) begin
            cnt_d   = '0;
            state_d = bus.SS_n ? S_IDLE : S_CMD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= rx_q;
  end

  assign bus.MISO      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.addr_err  = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave_v2.sv
`default_nettype none
// ============================================================================
// tb_spi_ram_slave_v2 : three configurations driven against a behavioural RAM model
// Revision: 2.0
// ============================================================================
module tb_spi_ram_slave_v2;
  logic clk = 1'b0;
  logic rst_n;
  logic ss_ab, mosi_ab, ss_c, mosi_c;
  always #5 clk = ~clk;

  spi_ram_slave_v2_if if_a ();
  spi_ram_slave_v2_if if_b ();
  spi_ram_slave_v2_if if_c ();

  assign if_a.SS_n = ss_ab;
  assign if_a.MOSI = mosi_ab;
  assign if_b.SS_n = ss_ab;
  assign if_b.MOSI = mosi_ab;
  assign if_c.SS_n = ss_c;
  assign if_c.MOSI = mosi_c;

  spi_ram_slave_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  spi_ram_slave_v2 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  spi_ram_slave_v2 #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .MEM_DEPTH(16), .AUTO_INC(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Reference model: index 0 = dut_a, 1 = dut_b, 2 = dut_c
  logic [15:0] mm [3][256];
  int wa [3];
  int ra [3];
  int depth [3] = '{256, 200, 16};
  int amask [3] = '{255, 255, 15};
  int dw    [3] = '{8, 8, 16};
  int inc   [3] = '{1, 1, 0};
  logic [15:0] got [3];
  logic [15:0] hold;
  int rd_abort_at = -1;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input logic [1:0] cmd, input logic [15:0] pl,
                            output logic [15:0] rd, output logic err);
    int dm;
    dm  = (1 << dw[d]) - 1;
    rd  = '0;
    err = 1'b0;
    case (cmd)
      2'd0: wa[d] = int'(pl) & amask[d];
      2'd1: begin
        if (wa[d] >= depth[d]) err = 1'b1;
        else begin
          mm[d][wa[d]] = 16'(int'(pl) & dm);
          if (inc[d] != 0) wa[d] = (wa[d] + 1) % depth[d];
        end
      end
      2'd2: ra[d] = int'(pl) & amask[d];
      default: begin
        if (ra[d] >= depth[d]) err = 1'b1;
        else begin
          rd = mm[d][ra[d]];
          if (inc[d] != 0) ra[d] = (ra[d] + 1) % depth[d];
        end
      end
    endcase
  endtask

  function automatic logic get_busy(input int d);
    if (d == 0) return if_a.busy;
    if (d == 1) return if_b.busy;
    return if_c.busy;
  endfunction
  function automatic logic get_miso(input int d);
    if (d == 0) return if_a.MISO;
    if (d == 1) return if_b.MISO;
    return if_c.MISO;
  endfunction
  function automatic logic get_ferr(input int d);
    if (d == 0) return if_a.frame_err;
    if (d == 1) return if_b.frame_err;
    return if_c.frame_err;
  endfunction
  function automatic logic get_aerr(input int d);
    if (d == 0) return if_a.addr_err;
    if (d == 1) return if_b.addr_err;
    return if_c.addr_err;
  endfunction

  task automatic drive(input int bus, input logic ss, input logic m);
    if (bus == 0) begin ss_ab = ss; mosi_ab = m; end
    else          begin ss_c  = ss; mosi_c  = m; end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input int bus);
    drive(bus, 1'b0, 1'b0);
    tick();
    for (int d = (bus != 0 ? 2 : 0); d <= (bus != 0 ? 2 : 1); d++) check("busy_start", 16'(get_busy(d)), 16'd1);
  endtask

  // One complete frame inside an ongoing SS_n assertion; last raises SS_n for the EXEC edge.
  task automatic frame(input int bus, input logic [1:0] cmd, input logic [15:0] pl, input bit last);
    int lo, hi, n;
    logic [15:0] exp_rd [3];
    logic        exp_err [3];
    lo = (bus != 0) ? 2 : 0;
    hi = (bus != 0) ? 2 : 1;
    n  = (bus != 0) ? 16 : 8;
    for (int d = lo; d <= hi; d++) model_step(d, cmd, pl, exp_rd[d], exp_err[d]);
    for (int i = 0; i < 2 + n; i++) begin
      drive(bus, 1'b0, (i < 2) ? cmd[1 - i] : pl[n + 1 - i]);
      tick();
      for (int d = lo; d <= hi; d++) begin
        check("busy_frame", 16'(get_busy(d)), 16'd1);
        check("miso_idle_bits", 16'(get_miso(d)), 16'd0);
      end
    end
    drive(bus, last, 1'b0);
    tick();
    for (int d = lo; d <= hi; d++) begin
      check("addr_err_exec", 16'(get_aerr(d)), 16'(exp_err[d]));
      check("frame_err_exec", 16'(get_ferr(d)), 16'd0);
      check("miso_exec", 16'(get_miso(d)), 16'd0);
      check("busy_exec", 16'(get_busy(d)), last ? 16'd0 : 16'd1);
    end
    if (cmd == 2'd3) begin
      for (int d = lo; d <= hi; d++) got[d] = '0;
      for (int k = 0; k < n; k++) begin
        if (k == rd_abort_at) begin
          drive(bus, 1'b1, 1'b0);
          tick();
          for (int d = lo; d <= hi; d++) begin
            check("frame_err_rd_abort", 16'(get_ferr(d)), 16'd1);
            check("miso_rd_abort", 16'(get_miso(d)), 16'd0);
            check("busy_rd_abort", 16'(get_busy(d)), 16'd0);
          end
          rd_abort_at = -1;
          return;
        end
        drive(bus, 1'b0, 1'($urandom));
        tick();
        for (int d = lo; d <= hi; d++) begin
          got[d][n - 1 - k] = get_miso(d);
          check("busy_read_out", 16'(get_busy(d)), 16'd1);
          if (k == 0) check("addr_err_pulse_len", 16'(get_aerr(d)), 16'd0);
        end
      end
      for (int d = lo; d <= hi; d++) check("rd_data", got[d], exp_rd[d]);
    end
  endtask

  task automatic abort_after(input int bus, input logic [1:0] cmd, input logic [15:0] pl, input int nbits);
    int lo, hi, n;
    lo = (bus != 0) ? 2 : 0;
    hi = (bus != 0) ? 2 : 1;
    n  = (bus != 0) ? 16 : 8;
    for (int i = 0; i < 2 + nbits; i++) begin
      drive(bus, 1'b0, (i < 2) ? cmd[1 - i] : pl[n + 1 - i]);
      tick();
    end
    drive(bus, 1'b1, 1'b0);
    tick();
    for (int d = lo; d <= hi; d++) begin
      check("frame_err_abort", 16'(get_ferr(d)), 16'd1);
      check("busy_abort", 16'(get_busy(d)), 16'd0);
      check("miso_abort", 16'(get_miso(d)), 16'd0);
    end
    tick();
    for (int d = lo; d <= hi; d++) check("frame_err_one_cycle", 16'(get_ferr(d)), 16'd0);
  endtask

  task automatic idle_flags(input string tag);
    for (int d = 0; d < 3; d++) begin
      check({tag, "_busy"}, 16'(get_busy(d)), 16'd0);
      check({tag, "_miso"}, 16'(get_miso(d)), 16'd0);
      check({tag, "_frame_err"}, 16'(get_ferr(d)), 16'd0);
      check({tag, "_addr_err"}, 16'(get_aerr(d)), 16'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c;
    logic [15:0] p;
    bit lst, active;
    rst_n = 1'b0; ss_ab = 1'b1; mosi_ab = 1'b0; ss_c = 1'b1; mosi_c = 1'b0;
    for (int d = 0; d < 3; d++) begin wa[d] = 0; ra[d] = 0; end
    repeat (3) @(negedge clk);
    idle_flags("reset");
    rst_n = 1'b1;
    tick();
    idle_flags("idle_after_reset");

    // Fill every word of both 8-bit configurations, then the 16-bit one
    start(0);
    frame(0, 2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 256; i++) frame(0, 2'd1, 16'($urandom), 1'b0);
    frame(0, 2'd2, 16'h0000, 1'b1);
    start(1);
    for (int i = 0; i < 16; i++) begin
      frame(1, 2'd0, 16'(i), 1'b0);
      frame(1, 2'd1, 16'($urandom), 1'b0);
    end
    frame(1, 2'd2, 16'h0000, 1'b1);

    // Single write / read
    start(0);
    frame(0, 2'd0, 16'h0010, 1'b0);
    frame(0, 2'd1, 16'h00A5, 1'b0);
    frame(0, 2'd2, 16'h0010, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("single_rd_a", got[0], 16'h00A5);
    check("single_rd_b", got[1], 16'h00A5);
    frame(0, 2'd2, 16'h0010, 1'b1);

    // Burst with wrap at the top of a 256-word RAM
    start(0);
    frame(0, 2'd0, 16'h00FE, 1'b0);
    frame(0, 2'd1, 16'h0011, 1'b0);
    frame(0, 2'd1, 16'h0022, 1'b0);
    frame(0, 2'd1, 16'h0033, 1'b0);
    frame(0, 2'd2, 16'h00FE, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("burst_rd0", got[0], 16'h0011);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("burst_rd1", got[0], 16'h0022);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("burst_rd2_wrap", got[0], 16'h0033);
    frame(0, 2'd0, 16'h0000, 1'b1);

    // Abort mid-payload: no write, address unchanged
    start(0);
    frame(0, 2'd0, 16'h0020, 1'b0);
    hold = mm[0][32];
    abort_after(0, 2'd1, 16'h00FF, 5);
    start(0);
    frame(0, 2'd2, 16'h0020, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("abort_mem_kept", got[0], hold);
    frame(0, 2'd1, 16'h0077, 1'b0);
    frame(0, 2'd2, 16'h0020, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("abort_wr_addr_kept", got[0], 16'h0077);
    frame(0, 2'd2, 16'h0000, 1'b1);

    // Out-of-range access on the 200-word configuration
    start(0);
    frame(0, 2'd0, 16'h00C8, 1'b0);
    frame(0, 2'd1, 16'h0055, 1'b1);
    drive(0, 1'b1, 1'b0);
    tick();
    check("oor_err_clear_a", 16'(get_aerr(0)), 16'd0);
    check("oor_err_clear_b", 16'(get_aerr(1)), 16'd0);
    start(0);
    frame(0, 2'd2, 16'h00C8, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("oor_rd_a", got[0], 16'h0055);
    check("oor_rd_b_zero", got[1], 16'h0000);
    frame(0, 2'd1, 16'h0066, 1'b0);
    frame(0, 2'd2, 16'h00C8, 1'b0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("oor_wr_addr_held_b", got[1], 16'h0000);
    frame(0, 2'd2, 16'h0000, 1'b1);

    // Abort in READ_OUT: the read-address step already taken stands
    start(0);
    frame(0, 2'd2, 16'h0005, 1'b0);
    rd_abort_at = 3;
    frame(0, 2'd3, 16'h0000, 1'b0);
    start(0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    frame(0, 2'd2, 16'h0000, 1'b1);

    // Held address, 16-bit words
    start(1);
    frame(1, 2'd2, 16'h0003, 1'b0);
    frame(1, 2'd3, 16'h0000, 1'b0);
    hold = got[2];
    frame(1, 2'd3, 16'hFFFF, 1'b0);
    check("noinc_same_word", got[2], hold);
    frame(1, 2'd2, 16'h0003, 1'b1);

    // Reset in mid-frame: partial write must not land
    start(0);
    frame(0, 2'd0, 16'h0000, 1'b0);
    frame(0, 2'd1, 16'h003C, 1'b1);
    start(0);
    frame(0, 2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, (i == 1) ? 1'b1 : 1'b0);
      tick();
    end
    #1 rst_n = 1'b0;
    ss_ab = 1'b1;
    #1;
    idle_flags("async_reset");
    for (int d = 0; d < 3; d++) begin wa[d] = 0; ra[d] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start(0);
    frame(0, 2'd3, 16'h0000, 1'b0);
    check("reset_no_partial_write", got[0], 16'h003C);
    frame(0, 2'd2, 16'h0000, 1'b1);

    // Randomised back-to-back traffic
    active = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!active) begin start(0); active = 1'b1; end
      c = 2'($urandom);
      p = ($urandom % 2 == 0) ? 16'($urandom_range(255, 180)) : 16'($urandom);
      lst = (c != 2'd3) && ($urandom % 4 == 0);
      frame(0, c, p, lst);
      if (lst) active = 1'b0;
    end
    if (active) frame(0, 2'd2, 16'h0000, 1'b1);
    active = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!active) begin start(1); active = 1'b1; end
      c = 2'($urandom);
      p = 16'($urandom);
      lst = (c != 2'd3) && ($urandom % 4 == 0);
      frame(1, c, p, lst);
      if (lst) active = 1'b0;
    end
    if (active) frame(1, 2'd2, 16'h0000, 1'b1);

    tick();
    idle_flags("final_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
